// File: rtl/data_reg_bank_stream.sv
// Parametrised DEPTH x WIDTH data register bank with parallel/addressed writes and a
// valid/ready stream-out engine. Optional synchronous clear port under REGBANK_CLEAR_EN.
module data_reg_bank_stream #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic [WIDTH*DEPTH-1:0]   inAll,
    input  logic                     writeAll,
    input  logic [WIDTH-1:0]         dataIn,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     writeAddress,
`ifdef REGBANK_CLEAR_EN
    input  logic                     clearAll,
`endif
    output logic [WIDTH*DEPTH-1:0]   outAll,
    input  logic                     streamStart,
    input  logic                     streamReady,
    output logic                     streamValid,
    output logic [WIDTH-1:0]         streamData,
    output logic [ADDR_W-1:0]        streamIndex,
    output logic                     streamBusy,
    output logic                     streamDone
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    state_t                      state_q, state_d;
    logic                        valid_q, valid_d;
    logic [WIDTH-1:0]            data_q, data_d;
    logic [ADDR_W-1:0]           index_q, index_d;
    logic                        done_q, done_d;

    always_comb begin
        mem_d = mem_q;
`ifdef REGBANK_CLEAR_EN
        if (clearAll) begin
            mem_d = '0;
        end else
`endif
        if (writeAll) begin
            mem_d = inAll;
        end else if (writeAddress && ({1'b0, address} < DEPTH_W)) begin
            mem_d[address] = dataIn;
        end
    end

    // Stream fetches always read mem_q, i.e. the contents before any same-edge write.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (streamStart) begin
                    data_d  = mem_q[0];
                    index_d = '0;
                    valid_d = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (valid_q && streamReady) begin
                    if (index_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        index_d = '0;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + 1'b1;
                        data_d  = mem_q[index_q + 1'b1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mem_q   <= '0;
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

    assign outAll      = mem_q;
    assign streamValid = valid_q;
    assign streamData  = data_q;
    assign streamIndex = index_q;
    assign streamBusy  = (state_q == STREAM);
    assign streamDone  = done_q;

endmodule

// File: tb/tb_data_reg_bank_stream.sv
// Scoreboard bench for data_reg_bank_stream: a queue-based reference model predicts every
// beat at fetch time, and a negedge monitor compares outputs against it.
module tb_data_reg_bank_stream;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 5;
    localparam int ADDR_W = 3;
    localparam int CW     = WIDTH * DEPTH;

    logic              clk = 1'b0;
    logic              resetN;
    logic [CW-1:0]     inAll;
    logic              writeAll;
    logic [WIDTH-1:0]  dataIn;
    logic [ADDR_W-1:0] address;
    logic              writeAddress;
    logic              clearAll;
    logic [CW-1:0]     outAll;
    logic              streamStart;
    logic              streamReady;
    logic              streamValid;
    logic [WIDTH-1:0]  streamData;
    logic [ADDR_W-1:0] streamIndex;
    logic              streamBusy;
    logic              streamDone;

    always #5 clk = ~clk;

    data_reg_bank_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk          (clk),
        .resetN       (resetN),
        .inAll        (inAll),
        .writeAll     (writeAll),
        .dataIn       (dataIn),
        .address      (address),
        .writeAddress (writeAddress),
`ifdef REGBANK_CLEAR_EN
        .clearAll     (clearAll),
`endif
        .outAll       (outAll),
        .streamStart  (streamStart),
        .streamReady  (streamReady),
        .streamValid  (streamValid),
        .streamData   (streamData),
        .streamIndex  (streamIndex),
        .streamBusy   (streamBusy),
        .streamDone   (streamDone)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        int unsigned      idx;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] mdl_mem[DEPTH] = '{default: '0};
    bit               mdl_busy = 1'b0;
    bit               mdl_done = 1'b0;
    int               mdl_idx  = 0;
    logic [CW-1:0]    exp_all;
    beat_t            front;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a stream is a sequence of DEPTH fetches, each reading the
    // word array as it stood before that edge's write.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            mdl_busy = 1'b0;
            mdl_done = 1'b0;
            mdl_idx  = 0;
            exp_q.delete();
        end else begin
            mdl_done = 1'b0;
            if (!mdl_busy) begin
                if (streamStart) begin
                    mdl_busy = 1'b1;
                    mdl_idx  = 0;
                    exp_q.push_back('{0, mdl_mem[0]});
                end
            end else if (streamReady) begin
                if (mdl_idx == DEPTH - 1) begin
                    mdl_busy = 1'b0;
                    mdl_done = 1'b1;
                    mdl_idx  = 0;
                end else begin
                    mdl_idx++;
                    exp_q.push_back('{mdl_idx, mdl_mem[mdl_idx]});
                end
            end
`ifdef REGBANK_CLEAR_EN
            if (clearAll) begin
                for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            end else
`endif
            if (writeAll) begin
                for (int i = 0; i < DEPTH; i++) mdl_mem[i] = inAll[i*WIDTH +: WIDTH];
            end else if (writeAddress && int'(address) < DEPTH) begin
                mdl_mem[address] = dataIn;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < DEPTH; i++) exp_all[i*WIDTH +: WIDTH] = mdl_mem[i];
        chk("outAll", outAll, exp_all);
        chk("streamValid", CW'(streamValid), CW'(mdl_busy));
        chk("streamBusy", CW'(streamBusy), CW'(mdl_busy));
        chk("streamDone", CW'(streamDone), CW'(mdl_done));
        if (streamDone) done_cnt++;
        if (streamValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat_unexpected: valid beat idx %0d data %0h with empty scoreboard",
                         streamIndex, streamData);
            end else begin
                front = exp_q[0];
                chk("streamData", CW'(streamData), CW'(front.data));
                chk("streamIndex", CW'(streamIndex), CW'(front.idx));
                if (streamReady) void'(exp_q.pop_front());
            end
        end else begin
            chk("idle_index", CW'(streamIndex), '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        writeAll     = 1'b0;
        writeAddress = 1'b0;
        streamStart  = 1'b0;
        clearAll     = 1'b0;
    endtask

    task automatic load_seq(input int base);
        for (int i = 0; i < DEPTH; i++) inAll[i*WIDTH +: WIDTH] = WIDTH'(base + i);
    endtask

    task automatic drain();
        int n;
        n = 0;
        quiet();
        streamReady = 1'b1;
        while (mdl_busy && n < 4 * DEPTH) begin
            step();
            n++;
        end
        step();
        if (mdl_busy) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: stream still busy after %0d cycles", n);
        end
    endtask

    int dc0;

    initial begin
        resetN = 1'b0;
        inAll  = '0;
        dataIn = '0;
        address = '0;
        streamReady = 1'b0;
        quiet();
        step();
        step();
        chk("reset_outAll", outAll, '0);
        chk("reset_data", CW'(streamData), '0);
        chk("reset_index", CW'(streamIndex), '0);
        resetN = 1'b1;
        step();

        load_seq(10);
        writeAll = 1'b1;
        step();
        quiet();
        for (int i = 0; i < DEPTH; i++)
            chk("load_word", CW'(outAll[i*WIDTH +: WIDTH]), CW'(10 + i));

        for (int i = 0; i < DEPTH; i++) begin
            writeAddress = 1'b1;
            address = ADDR_W'(i);
            dataIn = WIDTH'(i);
            step();
        end
        quiet();
        for (int i = 0; i < DEPTH; i++)
            chk("addr_word", CW'(outAll[i*WIDTH +: WIDTH]), CW'(i));

        load_seq(20);
        writeAll = 1'b1;
        writeAddress = 1'b1;
        address = 3'd2;
        dataIn = 32'd99;
        step();
        quiet();
        chk("priority_word2", CW'(outAll[2*WIDTH +: WIDTH]), CW'(22));

        for (int a = DEPTH; a < 8; a++) begin
            writeAddress = 1'b1;
            address = ADDR_W'(a);
            dataIn = 32'd55;
            step();
        end
        quiet();
        for (int i = 0; i < DEPTH; i++)
            chk("oob_word", CW'(outAll[i*WIDTH +: WIDTH]), CW'(20 + i));

        load_seq(10);
        writeAll = 1'b1;
        step();
        quiet();
        dc0 = done_cnt;
        streamStart = 1'b1;
        streamReady = 1'b1;
        step();
        streamStart = 1'b0;
        repeat (DEPTH + 2) step();
        chk("full_stream_done_count", CW'(done_cnt - dc0), CW'(1));
        chk("full_stream_idle", CW'(streamBusy), '0);

        streamStart = 1'b1;
        streamReady = 1'b1;
        step();
        streamStart = 1'b0;
        step();
        streamReady = 1'b0;
        writeAddress = 1'b1;
        address = 3'd1;
        dataIn = 32'd77;
        step();
        quiet();
        step();
        step();
        chk("stall_snapshot", CW'(streamData), CW'(11));
        drain();
        streamStart = 1'b1;
        step();
        streamStart = 1'b0;
        step();
        chk("restream_word1", CW'(streamData), CW'(77));
        drain();

        for (int c = 0; c < 3000; c++) begin
            streamStart  = ($urandom_range(0, 3) == 0);
            streamReady  = ($urandom_range(0, 3) != 0);
            writeAll     = ($urandom_range(0, 15) == 0);
            writeAddress = ($urandom_range(0, 3) == 0);
            address      = ADDR_W'($urandom_range(0, 7));
            dataIn       = $urandom;
            for (int i = 0; i < DEPTH; i++) inAll[i*WIDTH +: WIDTH] = $urandom;
`ifdef REGBANK_CLEAR_EN
            clearAll     = ($urandom_range(0, 31) == 0);
`endif
            step();
        end
        drain();

        load_seq(10);
        writeAll = 1'b1;
        step();
        quiet();
        dc0 = done_cnt;
        streamStart = 1'b1;
        streamReady = 1'b1;
        step();
        streamStart = 1'b0;
        step();
        step();
        chk("pre_reset_index", CW'(streamIndex), CW'(2));
        resetN = 1'b0;
        #1;
        chk("midreset_valid", CW'(streamValid), '0);
        chk("midreset_index", CW'(streamIndex), '0);
        chk("midreset_outAll", outAll, '0);
        step();
        resetN = 1'b1;
        repeat (3) step();
        chk("midreset_no_done", CW'(done_cnt - dc0), '0);

`ifdef REGBANK_CLEAR_EN
        load_seq(40);
        writeAll = 1'b1;
        step();
        quiet();
        dc0 = done_cnt;
        streamStart = 1'b1;
        streamReady = 1'b1;
        step();
        streamStart = 1'b0;
        step();
        clearAll = 1'b1;
        step();
        clearAll = 1'b0;
        step();
        chk("clear_later_beat", CW'(streamData), '0);
        drain();
        chk("clear_done_count", CW'(done_cnt - dc0), CW'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
